// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: resolves stage stall requests, sequences
// exception/ERET flushes as a registered one-cycle pulse, and tracks stall statistics.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        exc_valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout,
  output logic        dbg_state_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  localparam logic [31:0] WDOG_LIM = 32'(WDOG_LIMIT);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] run_q, run_d;
  logic        timeout_q, timeout_d;

  // Deepest requesting stage wins; everything upstream of it freezes too.
  always_comb begin
    stall = 6'b000000;
    if (state_q == RUN) begin
      if (stallreq_from_mem)     stall = 6'b011111;
      else if (stallreq_from_ex) stall = 6'b001111;
      else if (stallreq_from_id) stall = 6'b000111;
      else if (stallreq_from_if) stall = 6'b000011;
    end
  end

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    case (state_q)
      RUN: begin
        if (exc_valid_i && (excepttype_i != 32'h0)) begin
          state_d  = FLUSH;
          flush_d  = 1'b1;
          new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end
      end
      FLUSH: begin
        // Anything reported here comes from wrong-path bubbles.
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end

    run_d = run_q;
    if (WDOG_LIM == 32'd0 || state_q == FLUSH || !stall[0]) begin
      run_d = 32'd0;
    end else if (run_q < WDOG_LIM) begin
      run_d = run_q + 32'd1;
    end

    timeout_d = timeout_q;
    if ((WDOG_LIM != 32'd0) && (run_d == WDOG_LIM)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      flush_q        <= 1'b0;
      new_pc_q       <= 32'h0;
      stall_cycles_q <= 32'h0;
      run_q          <= 32'h0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      stall_cycles_q <= stall_cycles_d;
      run_q          <= run_d;
      timeout_q      <= timeout_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = timeout_q;
  assign dbg_state_o   = state_q;

endmodule
